// File: rtl/trace_checker_pkg.sv
// Shared trace definitions for the trace producer and trace_checker.
// Contents: the lane, line and index types, the trace event type enum,
// the packed trace event struct, the checker state and error-cause enums,
// and events_equal(), the per-type comparison helper.
package trace_checker_pkg;

    localparam int NUM_VECTOR_LANES = 4;
    localparam int CACHE_LINE_BYTES = 16;

    typedef logic [1:0]                        local_thread_idx_t;
    typedef logic [4:0]                        register_idx_t;
    typedef logic [NUM_VECTOR_LANES-1:0][31:0] vector_t;

    typedef enum logic [2:0] {
        TR_INVALID    = 3'd0,
        TR_SWRITEBACK = 3'd1,
        TR_VWRITEBACK = 3'd2,
        TR_STORE      = 3'd3,
        TR_INTERRUPT  = 3'd4
    } trace_event_type_t;

    typedef struct packed {
        trace_event_type_t                 ev_type;
        logic [31:0]                       pc;
        local_thread_idx_t                 thread_idx;
        register_idx_t                     reg_idx;
        logic [31:0]                       addr;
        logic [CACHE_LINE_BYTES-1:0]       mask;
        vector_t                           data;
    } trace_event_t;

    localparam int TRACE_EVENT_W = $bits(trace_event_t);

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISMATCH = 2'd1,
        CAUSE_OVERFLOW = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } error_cause_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FAILED = 1'b1
    } chk_state_t;

    // Per-type comparison: only the fields meaningful for the event type are
    // checked. Store data is viewed as bytes of the vector, which is exactly
    // one cache line wide.
    function automatic logic events_equal(input trace_event_t d, input trace_event_t e);
        logic                              eq;
        logic [8*CACHE_LINE_BYTES-1:0]     db;
        logic [8*CACHE_LINE_BYTES-1:0]     eb;
        eq = (d.ev_type == e.ev_type);
        db = d.data;
        eb = e.data;
        case (d.ev_type)
            TR_SWRITEBACK: begin
                eq = eq && (d.pc == e.pc) && (d.thread_idx == e.thread_idx)
                        && (d.reg_idx == e.reg_idx) && (d.data[0] == e.data[0]);
            end
            TR_VWRITEBACK: begin
                eq = eq && (d.pc == e.pc) && (d.thread_idx == e.thread_idx)
                        && (d.reg_idx == e.reg_idx)
                        && (d.mask[NUM_VECTOR_LANES-1:0] == e.mask[NUM_VECTOR_LANES-1:0]);
                for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
                    if (d.mask[i] && (d.data[i] != e.data[i])) begin
                        eq = 1'b0;
                    end else begin
                        eq = eq;
                    end
                end
            end
            TR_STORE: begin
                eq = eq && (d.pc == e.pc) && (d.thread_idx == e.thread_idx)
                        && (d.addr == e.addr) && (d.mask == e.mask);
                for (int i = 0; i < CACHE_LINE_BYTES; i++) begin
                    if (d.mask[i] && (db[8*i +: 8] != eb[8*i +: 8])) begin
                        eq = 1'b0;
                    end else begin
                        eq = eq;
                    end
                end
            end
            TR_INTERRUPT: begin
                eq = eq && (d.pc == e.pc) && (d.thread_idx == e.thread_idx);
            end
            default: begin
                // Invalid types are never buffered; treat as a mismatch.
                eq = 1'b0;
            end
        endcase
        return eq;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports: clk/reset (sync active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o is the current head), full_o, empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int               AW         = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];

    // Storage write; contents need no reset since count_q guards reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Trace checker: buffers DUT trace events and compares them in order
// against expected events from a reference model.
// Ports: clk/reset; dut_* event inputs (no backpressure); exp_* event
// inputs with exp_valid/exp_ready handshake; check_error, error_cause,
// fail_pc, fail_thread_idx (first error, sticky) and match_count.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dut_valid,
    input  logic [2:0]                  dut_type,
    input  logic [31:0]                 dut_pc,
    input  local_thread_idx_t           dut_thread_idx,
    input  register_idx_t               dut_reg,
    input  logic [31:0]                 dut_addr,
    input  logic [CACHE_LINE_BYTES-1:0] dut_mask,
    input  vector_t                     dut_data,
    input  logic                        exp_valid,
    input  logic [2:0]                  exp_type,
    input  logic [31:0]                 exp_pc,
    input  local_thread_idx_t           exp_thread_idx,
    input  register_idx_t               exp_reg,
    input  logic [31:0]                 exp_addr,
    input  logic [CACHE_LINE_BYTES-1:0] exp_mask,
    input  vector_t                     exp_data,
    output logic                        exp_ready,
    output logic                        check_error,
    output logic [1:0]                  error_cause,
    output logic [31:0]                 fail_pc,
    output local_thread_idx_t           fail_thread_idx,
    output logic [31:0]                 match_count
);
    localparam int          TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    chk_state_t        state_q, state_d;
    logic              check_error_q, check_error_d;
    error_cause_t      error_cause_q, error_cause_d;
    logic [31:0]       fail_pc_q, fail_pc_d;
    local_thread_idx_t fail_thread_q, fail_thread_d;
    logic [31:0]       match_count_q, match_count_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    trace_event_t      dut_ev_s;
    trace_event_t      exp_ev_s;
    trace_event_t      head_ev_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              mismatch_s;
    logic              overflow_s;
    logic              timeout_s;

    assign dut_ev_s = '{ev_type: trace_event_type_t'(dut_type), pc: dut_pc,
                        thread_idx: dut_thread_idx, reg_idx: dut_reg,
                        addr: dut_addr, mask: dut_mask, data: dut_data};
    assign exp_ev_s = '{ev_type: trace_event_type_t'(exp_type), pc: exp_pc,
                        thread_idx: exp_thread_idx, reg_idx: exp_reg,
                        addr: exp_addr, mask: exp_mask, data: exp_data};

    sync_fifo #(
        .WIDTH (TRACE_EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (dut_ev_s),
        .pop_i   (pop_s),
        .rdata_o (head_ev_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state, handshake, compare and first-error capture.
    always_comb begin
        state_d       = state_q;
        check_error_d = check_error_q;
        error_cause_d = error_cause_q;
        fail_pc_d     = fail_pc_q;
        fail_thread_d = fail_thread_q;
        match_count_d = match_count_q;
        tmo_d         = tmo_q;
        exp_ready     = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        mismatch_s    = 1'b0;
        overflow_s    = 1'b0;
        timeout_s     = 1'b0;
        case (state_q)
            ST_RUN: begin
                exp_ready  = !fifo_empty_s;
                pop_s      = exp_valid && exp_ready;
                push_s     = dut_valid && (dut_type != 3'd0);
                mismatch_s = pop_s && !events_equal(head_ev_s, exp_ev_s);
                // Push+pop on a full FIFO is a legal pass-through.
                overflow_s = push_s && fifo_full_s && !pop_s;
                // Fires on the edge where the wait count would reach the limit.
                timeout_s  = !pop_s && !fifo_empty_s && (tmo_q == TIMEOUT_LAST);
                if (pop_s || fifo_empty_s) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (mismatch_s) begin
                    state_d       = ST_FAILED;
                    check_error_d = 1'b1;
                    error_cause_d = CAUSE_MISMATCH;
                    fail_pc_d     = head_ev_s.pc;
                    fail_thread_d = head_ev_s.thread_idx;
                end else if (overflow_s) begin
                    state_d       = ST_FAILED;
                    check_error_d = 1'b1;
                    error_cause_d = CAUSE_OVERFLOW;
                    fail_pc_d     = dut_pc;
                    fail_thread_d = dut_thread_idx;
                end else if (timeout_s) begin
                    state_d       = ST_FAILED;
                    check_error_d = 1'b1;
                    error_cause_d = CAUSE_TIMEOUT;
                    fail_pc_d     = head_ev_s.pc;
                    fail_thread_d = head_ev_s.thread_idx;
                end else if (pop_s) begin
                    match_count_d = match_count_q + 32'd1;
                end else begin
                    match_count_d = match_count_q;
                end
            end
            ST_FAILED: begin
                state_d = ST_FAILED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            check_error_q <= 1'b0;
            error_cause_q <= CAUSE_NONE;
            fail_pc_q     <= 32'd0;
            fail_thread_q <= '0;
            match_count_q <= 32'd0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            check_error_q <= check_error_d;
            error_cause_q <= error_cause_d;
            fail_pc_q     <= fail_pc_d;
            fail_thread_q <= fail_thread_d;
            match_count_q <= match_count_d;
            tmo_q         <= tmo_d;
        end
    end

    assign check_error     = check_error_q;
    assign error_cause     = error_cause_q;
    assign fail_pc         = fail_pc_q;
    assign fail_thread_idx = fail_thread_q;
    assign match_count     = match_count_q;

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, the DUT-event buffer entries (power of two, ≥2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum cycles a buffered DUT event may wait for an expected event.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous active-high reset
REQ-004 SHALL have the DUT event inputs (no backpressure):
- dut_valid  in  1  DUT event present this cycle
- dut_type  in  3  0 invalid, 1 swriteback, 2 vwriteback, 3 store, 4 interrupt
- dut_pc  in  32  instruction PC
- dut_thread_idx  in  local_thread_idx_t  thread
- dut_reg  in  register_idx_t  writeback register
- dut_addr  in  32  store line address
- dut_mask  in  CACHE_LINE_BYTES  byte mask (store) or lane mask in the low NUM_VECTOR_LANES bits
- dut_data  in  vector_t  data
REQ-005 SHALL have the same seven fields prefixed exp_ as inputs, plus exp_valid (in, 1) and exp_ready (out, 1).
REQ-006 SHALL have the outputs:
- check_error  out  1  sticky failure
- error_cause  out  2  0 none, 1 mismatch, 2 overflow, 3 timeout
- fail_pc  out  32  DUT pc of the failing event
- fail_thread_idx  out  local_thread_idx_t  its thread
- match_count  out  32  events compared equal

Function
REQ-007 SHALL push every dut_valid event with dut_type≠0 into a FIFO_DEPTH FIFO, and SHALL ignore events with type 0.
REQ-008 SHALL run a state machine with states RUN and FAILED; reset enters RUN.
REQ-009 In RUN, exp_ready SHALL equal FIFO non-empty; one compare and pop of both heads occurs per cycle when exp_valid && exp_ready.
REQ-010 Compare rules: the types must be equal, then per type:
- swriteback: pc, thread, reg, data lane 0
- vwriteback: pc, thread, reg, mask[NUM_VECTOR_LANES-1:0], data lanes with mask bit set
- store: pc, thread, addr, full mask, data bytes with mask bit set
- interrupt: thread, pc
REQ-011 On an equal compare, match_count SHALL increment by 1, wrapping at 2^32.
REQ-012 On an unequal compare, the next cycle SHALL show state FAILED, check_error=1, error_cause=1, and fail_pc/fail_thread_idx from the DUT head.
REQ-013 When a push occurs while the FIFO is full and no pop occurs the same cycle, the block SHALL go to FAILED with cause 2, taking the fail fields from the dropped event.
REQ-014 A simultaneous push and pop on a full FIFO SHALL be legal and cause no overflow.
REQ-015 The timeout counter SHALL:
- clear on every pop and whenever the FIFO is empty
- otherwise increment each cycle
- on reaching TIMEOUT_CYCLES, send the block to FAILED with cause 3 and the fail fields from the DUT head
REQ-016 Error precedence in one cycle SHALL be mismatch > overflow > timeout; only the first error is latched.
REQ-017 In FAILED, the block SHALL:
- hold exp_ready at 0
- ignore pushes
- freeze all outputs until reset
REQ-018 Compare latency SHALL be 0 cycles to the pop and 1 cycle to the error/count outputs.

Reset
REQ-019 Reset SHALL take priority over all other inputs in the same cycle.
REQ-020 Reset SHALL set the following, including when asserted mid-operation or from FAILED:
- FIFO empty
- state RUN
- check_error=0, error_cause=0
- fail_pc=0, fail_thread_idx=0
- match_count=0
- timeout counter 0
- exp_ready=0

Structure
REQ-021 The trace event type enum and the packed trace event struct SHALL live in the shared defines package, so both the producer and this checker use them.
REQ-022 The buffer SHALL be the existing sync_fifo sub-module, instantiated with the packed event width; compare logic and the FSM stay in trace_checker.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- dut swriteback pc=0x100, thread 1, reg 5, lane0=0xDEADBEEF, then an identical exp event -> match_count=1, check_error=0.
- vwriteback with mask 0x0001 and data differing only in lane 3 -> match; then differing in lane 0 -> cause 1, fail_pc=event pc.
- 9 DUT events with exp_valid=0, FIFO_DEPTH=8 -> cause 2 on the 9th push cycle+1; then with a pop in the same cycle as the 9th push -> no error.
- one DUT event, exp_valid held 0 for 1024 cycles -> cause 3 exactly at count 1024.
- store with mask 0xF0 vs exp addr 0x1000 vs 0x1040 -> mismatch; a mismatch and an overflow in the same cycle -> cause 1.
- reset asserted in FAILED -> all outputs at reset values the next cycle, and a subsequent matching pair counts 1.
